adc_spi_cfg_engine: RTL and testbench
=====================================

ADC_SPI_CFG_ENGINE -- requirements
Module: adc_spi_cfg_engine

Parameters
REQ-001 SHALL have ADDR_W, default 8: frame address field width; MSB is the R/W bit, ADDR_W-1 address bits.
REQ-002 SHALL have DATA_W, default 8: frame data field width; FRAME_W = ADDR_W+DATA_W.
REQ-003 SHALL have CLK_DIV, default 4, legal range >=1: SCK half-period in clock cycles.
REQ-004 SHALL have CS_GAP, default 2, legal range >=1: cycles for each of ss setup, ss hold, and ss-high gap.
REQ-005 SHALL have VERIFY, default 1: 1 = every write is followed by a readback frame and compare.

Interface (name  direction  width  meaning)
REQ-006 FPGA_CLK1_32  in  1  sole clock, all logic on rising edge.
REQ-007 reset  in  1  synchronous, active-high.
REQ-008 cmd_valid  in  1  command offered.
REQ-009 cmd_ready  out  1  engine idle, command accepted when valid&ready.
REQ-010 cmd_rw  in  1  1=read, 0=write.
REQ-011 cmd_addr  in  ADDR_W-1  register address.
REQ-012 cmd_wdata  in  DATA_W  write data.
REQ-013 rsp_valid  out  1  one-cycle response pulse, no backpressure.
REQ-014 rsp_rdata  out  DATA_W  data bits captured from sdi, held until next rsp_valid.
REQ-015 rsp_err  out  1  verify mismatch, valid with rsp_valid.
REQ-016 busy  out  1  high from acceptance to rsp_valid inclusive.
REQ-017 ss  out  1  SPI chip select, active-low.
REQ-018 sck  out  1  SPI clock, mode 0.
REQ-019 sdo  out  1  SPI MOSI.
REQ-020 sdi  in  1  SPI MISO.

Function
REQ-021 States: IDLE, SETUP, SHIFT, HOLD, GAP, RESP; cmd_ready=1 only in IDLE.
REQ-022 Acceptance: address, data, and rw are latched on the valid&ready cycle (cycle 0); SETUP begins on cycle 1.
REQ-023 SETUP: ss=0, sck=0, sdo=frame MSB, for CS_GAP cycles, then SHIFT.
REQ-024 SHIFT: FRAME_W bits, MSB first, frame = {rw, addr, data}; read frames have data field 0.
REQ-025 SHIFT bit timing: each bit is 2*CLK_DIV cycles, sck low for the first CLK_DIV cycles and high for the second CLK_DIV cycles.
REQ-026 sdo changes only at bit start, while sck is low.
REQ-027 sdi is sampled on the cycle sck goes high; the last DATA_W samples form the captured data.
REQ-028 HOLD: ss=0, sck=0 for CS_GAP cycles; GAP: ss=1 for CS_GAP cycles.
REQ-029 After GAP, a read or a write with VERIFY=0 goes to RESP.
REQ-030 After GAP, a write with VERIFY=1 runs a second frame {1, addr, 0} through SETUP..GAP, then RESP.
REQ-031 RESP: rsp_valid=1 for one cycle, then IDLE; cmd_ready=1 on the following cycle.
REQ-032 Single-frame latency: rsp_valid at cycle 1+3*CS_GAP+2*CLK_DIV*FRAME_W (135 at defaults).
REQ-033 Verified-write latency: rsp_valid at cycle 1+2*(3*CS_GAP+2*CLK_DIV*FRAME_W) (269 at defaults).
REQ-034 rsp_err=1 iff VERIFY=1, the command was a write, and the readback data != cmd_wdata; otherwise 0.
REQ-035 For a non-verified write, rsp_rdata = data captured during that frame.
REQ-036 cmd_valid while busy is ignored: not latched, no effect on the current transfer.
REQ-037 Bit and cycle counters SHALL be sized for FRAME_W and CLK_DIV without wrap-around at the maximum parameter values.

Reset
REQ-038 While reset=1: ss=1, sck=0, sdo=0, cmd_ready=0, rsp_valid=0, rsp_err=0, busy=0, rsp_rdata=0, state=IDLE.
REQ-039 Reset mid-transfer aborts on the next edge with no rsp_valid; cmd_ready=1 on the first cycle after reset falls.
REQ-040 reset and cmd_valid in the same cycle: reset wins, command not accepted.

Verification
REQ-041 Read: addr 0x05, slave drives 0xA5 -> sdo frame 0x8500, 16 sck rising edges, rsp_valid at cycle 135, rsp_rdata=0xA5, rsp_err=0.
REQ-042 Verified write, echoing slave: addr 0x11, wdata 0x3C -> frames 0x113C then 0x9100, rsp_valid at cycle 269, rsp_err=0.
REQ-043 Verify mismatch: same write, slave returns 0x3D on readback -> rsp_err=1, rsp_rdata=0x3D.
REQ-044 Reset asserted at cycle 40 (SHIFT) -> next cycle ss=1, sck=0, no rsp_valid; a new read completes normally after release.
REQ-045 cmd_valid held high for two reads -> second accepted exactly one cycle after the first rsp_valid; ss high for >=CS_GAP cycles between frames.
REQ-046 CLK_DIV=2, VERIFY=0 -> 4-cycle sck period, rsp_valid at cycle 71.

Source files
------------

// File: rtl/adc_spi_cfg_engine_if.sv
// Command/response bundle for adc_spi_cfg_engine.
//   master : command source (drives cmd_*, observes ready/response/busy)
//   slave  : the engine (accepts cmd_*, drives ready/response/busy)
// Signals:
//   cmd_valid/cmd_ready : command handshake, accepted on valid&ready
//   cmd_rw              : 1 = read, 0 = write
//   cmd_addr            : register address (ADDR_W-1 bits)
//   cmd_wdata           : write data
//   rsp_valid           : single-cycle response pulse
//   rsp_rdata           : data captured from the slave, held until next response
//   rsp_err             : readback mismatch on a verified write
//   busy                : transfer in progress up to and including the response
interface adc_spi_cfg_engine_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_rw;
  logic [ADDR_W-2:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              busy;

  modport master (
    output cmd_valid, cmd_rw, cmd_addr, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  cmd_valid, cmd_rw, cmd_addr, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/adc_spi_cfg_engine.sv
// SPI configuration engine for an ADC register file (SPI mode 0).
// A command {rw, addr, wdata} is shifted out as one frame {rw, addr, data}
// MSB first; read frames carry a zero data field. With VERIFY=1 every write
// is followed by a readback frame {1, addr, 0} and the returned data is
// compared with the written data.
// Ports:
//   FPGA_CLK1_32 : sole clock, rising edge
//   reset        : synchronous, active-high
//   cmd          : command/response bundle (slave modport)
//   ss           : chip select, active-low
//   sck          : SPI clock, idle low
//   sdo          : MOSI
//   sdi          : MISO
module adc_spi_cfg_engine #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned CS_GAP  = 2,
  parameter int unsigned VERIFY  = 1
) (
  input  logic                 FPGA_CLK1_32,
  input  logic                 reset,
  adc_spi_cfg_engine_if.slave  cmd,
  output logic                 ss,
  output logic                 sck,
  output logic                 sdo,
  input  logic                 sdi
);

  localparam int unsigned FRAME_W = ADDR_W + DATA_W;
  localparam int unsigned BIT_W   = $clog2(FRAME_W + 1);
  localparam int unsigned DIV_W   = $clog2(2 * CLK_DIV + 1);
  localparam int unsigned GAP_W   = $clog2(CS_GAP + 1);

  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(FRAME_W - 1);
  localparam logic [DIV_W-1:0]  DIV_HI    = DIV_W'(CLK_DIV);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(2 * CLK_DIV - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(CS_GAP - 1);
  localparam logic [DATA_W-1:0] DATA_ZERO = '0;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP, RESP} state_t;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [FRAME_W-1:0]  tx_q, tx_d;
  logic [DATA_W-1:0]   rx_q, rx_d;
  logic                rw_q, rw_d;
  logic [ADDR_W-2:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                second_q, second_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                gap_done;

  assign gap_done = (gap_q == GAP_LAST);

  always_ff @(posedge FPGA_CLK1_32) begin
    if (reset) begin
      state_q  <= IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      gap_q    <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
      rw_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      second_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      gap_q    <= gap_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      rw_q     <= rw_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      second_q <= second_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    gap_d    = gap_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    rw_d     = rw_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    second_d = second_q;
    rdata_d  = rdata_q;
    err_d    = err_q;

    case (state_q)
      IDLE: begin
        if (cmd.cmd_valid) begin
          rw_d     = cmd.cmd_rw;
          addr_d   = cmd.cmd_addr;
          wdata_d  = cmd.cmd_wdata;
          tx_d     = {cmd.cmd_rw, cmd.cmd_addr,
                      cmd.cmd_rw ? DATA_ZERO : cmd.cmd_wdata};
          second_d = 1'b0;
          gap_d    = '0;
          state_d  = SETUP;
        end
      end

      SETUP: begin
        if (gap_done) begin
          gap_d   = '0;
          div_d   = '0;
          bit_d   = '0;
          state_d = SHIFT;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      SHIFT: begin
        div_d = div_q + 1'b1;
        // Sample on the first sck-high cycle; the register keeps only the
        // trailing DATA_W samples, i.e. the data field.
        if (div_q == DIV_HI) begin
          rx_d = DATA_W'({rx_q, sdi});
        end
        // Advance at the end of the bit so sdo changes while sck is low.
        if (div_q == DIV_LAST) begin
          div_d = '0;
          tx_d  = tx_q << 1;
          if (bit_q == BIT_LAST) begin
            gap_d   = '0;
            state_d = HOLD;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end

      HOLD: begin
        if (gap_done) begin
          gap_d   = '0;
          state_d = GAP;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      GAP: begin
        if (gap_done) begin
          gap_d = '0;
          if ((VERIFY != 0) && !rw_q && !second_q) begin
            second_d = 1'b1;
            tx_d     = {1'b1, addr_q, DATA_ZERO};
            state_d  = SETUP;
          end else begin
            rdata_d = rx_q;
            err_d   = (VERIFY != 0) && !rw_q && (rx_q != wdata_q);
            state_d = RESP;
          end
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are forced to their idle values combinationally while reset is
  // asserted, so they are quiet even before the first reset edge.
  assign cmd.cmd_ready = !reset && (state_q == IDLE);
  assign cmd.busy      = !reset && (state_q != IDLE);
  assign cmd.rsp_valid = !reset && (state_q == RESP);
  assign cmd.rsp_rdata = reset ? DATA_ZERO : rdata_q;
  assign cmd.rsp_err   = !reset && err_q;

  assign ss  = reset || !((state_q == SETUP) || (state_q == SHIFT) || (state_q == HOLD));
  assign sck = !reset && (state_q == SHIFT) && (div_q >= DIV_HI);
  assign sdo = !reset && ((state_q == SETUP) || (state_q == SHIFT)) && tx_q[FRAME_W-1];

endmodule

// File: tb/tb_adc_spi_cfg_engine.sv
// Directed bench for adc_spi_cfg_engine: a default-parameter instance with a
// behavioural SPI slave, plus a CLK_DIV=2 / VERIFY=0 instance with sdi tied high.
module tb_adc_spi_cfg_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  adc_spi_cfg_engine_if #(.ADDR_W(8), .DATA_W(8)) if0 ();
  adc_spi_cfg_engine_if #(.ADDR_W(8), .DATA_W(8)) if1 ();

  logic ss0, sck0, sdo0;
  logic sdi0 = 1'b0;
  logic ss1, sck1, sdo1;

  adc_spi_cfg_engine #(
    .ADDR_W(8), .DATA_W(8), .CLK_DIV(4), .CS_GAP(2), .VERIFY(1)
  ) u_dut0 (
    .FPGA_CLK1_32(clk), .reset(rst), .cmd(if0),
    .ss(ss0), .sck(sck0), .sdo(sdo0), .sdi(sdi0)
  );

  adc_spi_cfg_engine #(
    .ADDR_W(8), .DATA_W(8), .CLK_DIV(2), .CS_GAP(2), .VERIFY(0)
  ) u_dut1 (
    .FPGA_CLK1_32(clk), .reset(rst), .cmd(if1),
    .ss(ss1), .sck(sck1), .sdo(sdo1), .sdi(1'b1)
  );

  // Behavioural slave for instance 0: one MISO word per frame, MOSI logged per frame.
  logic [15:0] miso_word [16];
  logic [15:0] mosi_log  [16];
  int   frame_idx = 0;
  int   bitk      = 0;
  int   sck_rises = 0;
  int   hi_run    = 0;
  int   last_gap  = 0;
  int   rsp_cnt0  = 0;
  logic ss_prev0  = 1'b1;
  logic sck_prev0 = 1'b0;

  always @(negedge clk) begin
    int fi;
    fi = frame_idx % 16;
    if (!ss0 && ss_prev0) begin
      bitk         = 0;
      mosi_log[fi] = '0;
      sdi0         = miso_word[fi][15];
    end else if (!ss0 && sck_prev0 && !sck0) begin
      sdi0 = (bitk < 16) ? miso_word[fi][15-bitk] : 1'b0;
    end
    if (!ss0 && !sck_prev0 && sck0) begin
      mosi_log[fi] = {mosi_log[fi][14:0], sdo0};
      bitk++;
      sck_rises++;
    end
    if (ss0 && !ss_prev0) frame_idx++;
    if (ss0) hi_run++;
    else begin
      if (ss_prev0) last_gap = hi_run;
      hi_run = 0;
    end
    if (if0.rsp_valid) rsp_cnt0++;
    ss_prev0  = ss0;
    sck_prev0 = sck0;
  end

  // Instance 1 monitor: sck period and MOSI frame.
  int          per1 = 0;
  int          last_rise1 = 0;
  logic [15:0] mosi1 = '0;
  logic        sck_prev1 = 1'b0;

  always @(negedge clk) begin
    if (!sck_prev1 && sck1) begin
      per1       = cyc - last_rise1;
      last_rise1 = cyc;
      mosi1      = {mosi1[14:0], sdo1};
    end
    sck_prev1 = sck1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issues one command on instance sel and waits for its response.
  // lat counts cycles from the acceptance cycle (cycle 0) to rsp_valid; -1 on timeout.
  task automatic run_cmd(input bit sel, input bit hold, input logic rw,
                         input logic [6:0] addr, input logic [7:0] wd,
                         output int waited, output int lat,
                         output logic [7:0] rd, output logic er, output logic bsy);
    @(negedge clk);
    if (sel) begin
      if1.cmd_rw = rw; if1.cmd_addr = addr; if1.cmd_wdata = wd; if1.cmd_valid = 1'b1;
    end else begin
      if0.cmd_rw = rw; if0.cmd_addr = addr; if0.cmd_wdata = wd; if0.cmd_valid = 1'b1;
    end
    waited = 0;
    while (!(sel ? if1.cmd_ready : if0.cmd_ready) && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    lat = -1; rd = '0; er = 1'b0; bsy = 1'b0;
    for (int k = 1; k <= 600; k++) begin
      @(negedge clk);
      if (k == 1 && !hold) begin
        if0.cmd_valid = 1'b0;
        if1.cmd_valid = 1'b0;
      end
      if (k == 2) bsy = sel ? if1.busy : if0.busy;
      if (sel ? if1.rsp_valid : if0.rsp_valid) begin
        lat = k;
        rd  = sel ? if1.rsp_rdata : if0.rsp_rdata;
        er  = sel ? if1.rsp_err : if0.rsp_err;
        break;
      end
    end
  endtask

  initial begin
    int w, lat, f, s0, r0;
    logic [7:0] rd;
    logic er, bs;

    if0.cmd_valid = 1'b0; if0.cmd_rw = 1'b0; if0.cmd_addr = '0; if0.cmd_wdata = '0;
    if1.cmd_valid = 1'b0; if1.cmd_rw = 1'b0; if1.cmd_addr = '0; if1.cmd_wdata = '0;
    for (int i = 0; i < 16; i++) miso_word[i] = '0;

    // Reset values
    repeat (3) @(negedge clk);
    check_eq("rst_ss",    {31'd0, ss0}, 32'd1);
    check_eq("rst_sck",   {31'd0, sck0}, 32'd0);
    check_eq("rst_sdo",   {31'd0, sdo0}, 32'd0);
    check_eq("rst_ready", {31'd0, if0.cmd_ready}, 32'd0);
    check_eq("rst_rsp",   {31'd0, if0.rsp_valid}, 32'd0);
    check_eq("rst_busy",  {31'd0, if0.busy}, 32'd0);
    check_eq("rst_err",   {31'd0, if0.rsp_err}, 32'd0);
    check_eq("rst_rdata", {24'd0, if0.rsp_rdata}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("ready_after_rst", {31'd0, if0.cmd_ready}, 32'd1);

    // Read addr 0x05, slave returns 0xA5
    f = frame_idx; s0 = sck_rises;
    miso_word[f % 16] = 16'h00A5;
    run_cmd(1'b0, 1'b0, 1'b1, 7'h05, 8'h00, w, lat, rd, er, bs);
    check_eq("rd_lat",   lat, 32'd135);
    check_eq("rd_data",  {24'd0, rd}, 32'h0000_00A5);
    check_eq("rd_err",   {31'd0, er}, 32'd0);
    check_eq("rd_busy",  {31'd0, bs}, 32'd1);
    check_eq("rd_frame", {16'd0, mosi_log[f % 16]}, 32'h0000_8500);
    check_eq("rd_sck",   sck_rises - s0, 32'd16);
    @(negedge clk);
    check_eq("rd_ready_next", {31'd0, if0.cmd_ready}, 32'd1);
    check_eq("rd_rsp_one",    {31'd0, if0.rsp_valid}, 32'd0);

    // Verified write, echoing slave
    f = frame_idx;
    miso_word[f % 16]       = 16'h0000;
    miso_word[(f + 1) % 16] = 16'h003C;
    run_cmd(1'b0, 1'b0, 1'b0, 7'h11, 8'h3C, w, lat, rd, er, bs);
    check_eq("vw_lat",    lat, 32'd269);
    check_eq("vw_err",    {31'd0, er}, 32'd0);
    check_eq("vw_rdata",  {24'd0, rd}, 32'h0000_003C);
    check_eq("vw_frame0", {16'd0, mosi_log[f % 16]}, 32'h0000_113C);
    check_eq("vw_frame1", {16'd0, mosi_log[(f + 1) % 16]}, 32'h0000_9100);
    check_eq("vw_gap",    last_gap, 32'd2);

    // Verify mismatch
    f = frame_idx;
    miso_word[f % 16]       = 16'h0000;
    miso_word[(f + 1) % 16] = 16'h003D;
    run_cmd(1'b0, 1'b0, 1'b0, 7'h11, 8'h3C, w, lat, rd, er, bs);
    check_eq("mm_lat",   lat, 32'd269);
    check_eq("mm_err",   {31'd0, er}, 32'd1);
    check_eq("mm_rdata", {24'd0, rd}, 32'h0000_003D);

    // Reset in the middle of SHIFT
    @(negedge clk);
    if0.cmd_rw = 1'b1; if0.cmd_addr = 7'h05; if0.cmd_wdata = '0; if0.cmd_valid = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) if0.cmd_valid = 1'b0;
    end
    check_eq("mid_sck_running", {31'd0, ss0}, 32'd0);
    rst = 1'b1;
    r0 = rsp_cnt0;
    @(negedge clk);
    check_eq("abort_ss",   {31'd0, ss0}, 32'd1);
    check_eq("abort_sck",  {31'd0, sck0}, 32'd0);
    check_eq("abort_busy", {31'd0, if0.busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("abort_ready", {31'd0, if0.cmd_ready}, 32'd1);
    repeat (150) @(negedge clk);
    check_eq("abort_no_rsp", rsp_cnt0 - r0, 32'd0);
    f = frame_idx;
    miso_word[f % 16] = 16'h00C3;
    run_cmd(1'b0, 1'b0, 1'b1, 7'h05, 8'h00, w, lat, rd, er, bs);
    check_eq("post_rst_lat",  lat, 32'd135);
    check_eq("post_rst_data", {24'd0, rd}, 32'h0000_00C3);

    // Two reads with cmd_valid held high
    f = frame_idx;
    miso_word[f % 16]       = 16'h00A5;
    miso_word[(f + 1) % 16] = 16'h005A;
    run_cmd(1'b0, 1'b1, 1'b1, 7'h05, 8'h00, w, lat, rd, er, bs);
    check_eq("b2b_lat0",  lat, 32'd135);
    check_eq("b2b_data0", {24'd0, rd}, 32'h0000_00A5);
    run_cmd(1'b0, 1'b0, 1'b1, 7'h06, 8'h00, w, lat, rd, er, bs);
    check_eq("b2b_wait",  w, 32'd0);
    check_eq("b2b_lat1",  lat, 32'd135);
    check_eq("b2b_data1", {24'd0, rd}, 32'h0000_005A);
    check_eq("b2b_frame1", {16'd0, mosi_log[(f + 1) % 16]}, 32'h0000_8600);
    check_eq("b2b_gap_ge", {31'd0, (last_gap >= 2)}, 32'd1);

    // Reset together with cmd_valid: command must not be taken
    @(negedge clk);
    rst = 1'b1;
    if0.cmd_rw = 1'b1; if0.cmd_addr = 7'h05; if0.cmd_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    if0.cmd_valid = 1'b0;
    @(negedge clk);
    check_eq("rst_cmd_busy", {31'd0, if0.busy}, 32'd0);
    check_eq("rst_cmd_ss",   {31'd0, ss0}, 32'd1);

    // CLK_DIV=2, VERIFY=0 instance, sdi held high
    mosi1 = '0;
    run_cmd(1'b1, 1'b0, 1'b0, 7'h22, 8'h55, w, lat, rd, er, bs);
    check_eq("d2_lat",    lat, 32'd71);
    check_eq("d2_rdata",  {24'd0, rd}, 32'h0000_00FF);
    check_eq("d2_err",    {31'd0, er}, 32'd0);
    check_eq("d2_period", per1, 32'd4);
    check_eq("d2_frame",  {16'd0, mosi1}, 32'h0000_2255);
    check_eq("d2_ss_idle", {31'd0, ss1}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
